ps2_rx_fifo: RTL
================

Name: ps2_rx_fifo

Overview:
Parametrised PS/2 device-to-host receiver, successor to the single-byte keyboard receiver. Adds a glitch filter on ps2clk, a frame timeout, and separate parity and stop-bit error reporting. Folds E0/F0 prefix bytes into flags on the following code byte. Buffers decoded scan codes in a FIFO drained by a valid/ready handshake, so the CPU-side keyboard controller can read codes without losing keystrokes.

Parameters:
FIFO_DEPTH, 8, number of decoded entries buffered; power of 2, at least 2
FILTER_LEN, 4, consecutive equal synchronised samples required before the filtered ps2clk changes; at least 1
TIMEOUT_CYCLES, 50000, clk cycles without a sample edge, mid-frame, before the frame is aborted
CNT_W, $clog2(FIFO_DEPTH)+1, width of fifo_count

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
ps2clk  in  1  raw PS/2 clock pin
ps2data  in  1  raw PS/2 data pin
m_valid  out  1  FIFO head entry valid
m_ready  in  1  consumer accepts the head entry this cycle
m_code  out  8  head scan code
m_e0  out  1  head code was preceded by E0
m_break  out  1  head code was preceded by F0 (key release)
fifo_count  out  CNT_W  entries currently stored
parity_err  out  1  one-cycle pulse: bad parity
frame_err  out  1  one-cycle pulse: stop bit was 0
timeout_err  out  1  one-cycle pulse: frame aborted by timeout
overflow  out  1  one-cycle pulse: decoded entry dropped because the FIFO was full

Behaviour:
- Reset (asynchronous, any time including mid-frame):
  - FSM goes to IDLE; synchronisers and filtered clock go to 1; prefix flags clear; FIFO empties.
  - All outputs are 0 (m_code, fifo_count and all pulses included).
- Input conditioning:
  - ps2clk and ps2data each pass through a 2-FF synchroniser.
  - The filtered clock takes the synchronised ps2clk value only after FILTER_LEN consecutive identical samples.
  - Sample event = filtered clock 1->0. The bit sampled is the synchronised ps2data in that same cycle.
- Frame FSM: IDLE -> DATA -> PARITY -> STOP -> IDLE.
  - IDLE: sample event with data=0 -> DATA, bit counter=0. Data=1 is ignored.
  - DATA: 8 sample events, LSB first, shifted into a byte register. After the 8th -> PARITY.
  - PARITY: odd parity required, i.e. XOR of the 8 data bits and the parity bit = 1. The result is stored -> STOP.
  - STOP: requires data=1.
    - Parity bad: parity_err pulse.
    - Parity good, stop bit 0: frame_err pulse.
    - Both bad: both pulses.
    - Both good: byte_done for one cycle.
    - Always -> IDLE.
  - Timeout counter resets on every sample event and is held at 0 in IDLE. Reaching TIMEOUT_CYCLES in DATA, PARITY or STOP -> IDLE and timeout_err pulse.
  - Any error or timeout clears both prefix flags.
- Decoder (on byte_done):
  - Byte F0: set pend_break, no push.
  - Byte E0: set pend_e0, no push.
  - Any other byte: push {pend_e0, pend_break, byte}, then clear both flags. Flags clear even if the push is dropped.
- FIFO:
  - Push occurs in the cycle after byte_done. With the FIFO empty, m_valid rises 1 cycle after the stop-bit sample event.
  - Pop occurs when m_valid && m_ready. Outputs show the head entry combinationally from storage; m_code and flags are don't-care while m_valid=0.
  - Push while full and no pop in the same cycle: entry dropped, overflow pulse, contents unchanged.
  - Push while full with a pop in the same cycle: accepted, count unchanged.
  - Push and pop while non-full: count unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - fifo_count ranges 0..FIFO_DEPTH.
  - m_valid = (fifo_count != 0).

Test Plan:
- Clean make code: frame 0x1C (start 0, bits 0011_1000 LSB first, parity 0, stop 1), m_ready=1 -> single m_valid cycle with m_code=0x1C, m_e0=0, m_break=0; no error pulses.
- Prefixed release: frames E0, F0, 75, m_ready=0 -> fifo_count=1, head {e0=1, break=1, code=0x75}. Then frame 1C -> second entry {0,0,0x1C}; fifo_count=2.
- Errors: 0x1C with parity=1 -> parity_err pulse, no push. 0x1C with stop=0 -> frame_err pulse, no push. F0 followed by a bad frame, then 1C -> entry has break=0.
- Timeout and glitch, with TIMEOUT_CYCLES=1000, FILTER_LEN=4:
  - Halt ps2clk after 4 data bits -> timeout_err exactly 1000 cycles after the last sample event. The next clean 0x1C frame is received correctly.
  - A 2-cycle ps2clk low glitch causes no sample event.
- Overflow and wrap, with FIFO_DEPTH=4, m_ready=0:
  - Send codes 01..05 -> fifo_count=4, overflow pulse on 05, drained order 01,02,03,04.
  - Repeat 3 times to exercise pointer wrap.
  - Full FIFO with a simultaneous pop and push -> count stays 4.
- Reset mid-frame: assert rst after 5 data bits -> all outputs 0 immediately. After release, a full 0x1C frame yields exactly one correct entry.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronisers, ps2clk glitch filter, framed
// bit FSM with timeout, E0/F0 prefix folding and a valid/ready output FIFO.
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CNT_W          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ps2clk,
  input  logic             ps2data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [7:0]       m_code,
  output logic             m_e0,
  output logic             m_break,
  output logic [CNT_W-1:0] fifo_count,
  output logic             parity_err,
  output logic             frame_err,
  output logic             timeout_err,
  output logic             overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t          state_q, state_d;
  logic [1:0]      clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
  logic            flt_q, flt_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            par_ok_q, par_ok_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            pend_e0_q, pend_e0_d, pend_break_q, pend_break_d;
  logic            parity_err_q, parity_err_d, frame_err_q, frame_err_d;
  logic            timeout_err_q, timeout_err_d, overflow_q, overflow_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]      mem_q [FIFO_DEPTH];

  logic sample, bit_in, tmo_hit, byte_done, push_req, pop, full, wr_en;
  logic [9:0] head;

  // Input conditioning: 2-FF synchronisers, then a run-length filter on ps2clk.
  // The filtered clock follows only after FILTER_LEN samples disagreeing with it.
  always_comb begin
    clk_sync_d = {clk_sync_q[0], ps2clk};
    dat_sync_d = {dat_sync_q[0], ps2data};
    flt_d      = flt_q;
    fcnt_d     = '0;
    if (clk_sync_q[1] != flt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) flt_d = clk_sync_q[1];
      else                               fcnt_d = fcnt_q + 1'b1;
    end
    sample = flt_q & ~flt_d;
    bit_in = dat_sync_q[1];
  end

  // Frame FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and frame datapath: bit shifting, parity capture, timeout count.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    par_ok_d = par_ok_q;
    tmo_d    = '0;
    tmo_hit  = 1'b0;
    case (state_q)
      S_IDLE:   if (sample && !bit_in) begin
                  state_d  = S_DATA;
                  bitcnt_d = '0;
                end
      S_DATA:   if (sample) begin
                  shreg_d  = {bit_in, shreg_q[7:1]};
                  bitcnt_d = bitcnt_q + 3'd1;
                  if (bitcnt_q == 3'd7) state_d = S_PARITY;
                end
      S_PARITY: if (sample) begin
                  par_ok_d = ^{shreg_q, bit_in};
                  state_d  = S_STOP;
                end
      S_STOP:   if (sample) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // Idle keeps the counter at zero; mid-frame it counts cycles since the last sample.
    if (state_q != S_IDLE && !sample) begin
      if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        tmo_hit = 1'b1;
        state_d = S_IDLE;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  // Frame outcome, prefix folding and FIFO control.
  always_comb begin
    byte_done     = (state_q == S_STOP) && sample && par_ok_q && bit_in;
    parity_err_d  = (state_q == S_STOP) && sample && !par_ok_q;
    frame_err_d   = (state_q == S_STOP) && sample && !bit_in;
    timeout_err_d = tmo_hit;
    push_req      = byte_done && (shreg_q != 8'hF0) && (shreg_q != 8'hE0);
    pend_e0_d     = pend_e0_q;
    pend_break_d  = pend_break_q;
    if (parity_err_d || frame_err_d || tmo_hit) begin
      pend_e0_d    = 1'b0;
      pend_break_d = 1'b0;
    end else if (byte_done) begin
      if (shreg_q == 8'hF0)      pend_break_d = 1'b1;
      else if (shreg_q == 8'hE0) pend_e0_d    = 1'b1;
      else begin
        pend_e0_d    = 1'b0;
        pend_break_d = 1'b0;
      end
    end
    pop        = (cnt_q != '0) && m_ready;
    full       = (cnt_q == CNT_W'(FIFO_DEPTH));
    wr_en      = push_req && (!full || pop);
    overflow_d = push_req && full && !pop;
    wr_ptr_d   = wr_ptr_q + AW'(wr_en);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    cnt_d      = cnt_q + CNT_W'(wr_en) - CNT_W'(pop);
  end

  // Datapath and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q    <= 2'b11;
      dat_sync_q    <= 2'b11;
      flt_q         <= 1'b1;
      fcnt_q        <= '0;
      bitcnt_q      <= '0;
      shreg_q       <= '0;
      par_ok_q      <= 1'b0;
      tmo_q         <= '0;
      pend_e0_q     <= 1'b0;
      pend_break_q  <= 1'b0;
      parity_err_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      overflow_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
    end else begin
      clk_sync_q    <= clk_sync_d;
      dat_sync_q    <= dat_sync_d;
      flt_q         <= flt_d;
      fcnt_q        <= fcnt_d;
      bitcnt_q      <= bitcnt_d;
      shreg_q       <= shreg_d;
      par_ok_q      <= par_ok_d;
      tmo_q         <= tmo_d;
      pend_e0_q     <= pend_e0_d;
      pend_break_q  <= pend_break_d;
      parity_err_q  <= parity_err_d;
      frame_err_q   <= frame_err_d;
      timeout_err_q <= timeout_err_d;
      overflow_q    <= overflow_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
    end
  end

  // FIFO storage; contents need no reset because outputs are gated by m_valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {pend_e0_q, pend_break_q, shreg_q};
  end

  assign head        = mem_q[rd_ptr_q];
  assign m_valid     = (cnt_q != '0);
  assign m_code      = m_valid ? head[7:0] : 8'h00;
  assign m_break     = m_valid & head[8];
  assign m_e0        = m_valid & head[9];
  assign fifo_count  = cnt_q;
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign timeout_err = timeout_err_q;
  assign overflow    = overflow_q;

endmodule
